// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : synth_pkg
// Description : Shared synth constants, oscillator state encoding, ROM widths.
// Revision    : 1.0
// ============================================================================
package synth_pkg;

    localparam int NBIT_PERIOD_DEF = 16;
    localparam int NBIT_STEP_DEF   = 6;
    localparam int NBIT_OUT_DEF    = 16;

    // Note -> period ROM geometry feeding the oscillator stage
    localparam int ROM_NBIT_ADDR = 7;
    localparam int ROM_DEPTH     = 1 << ROM_NBIT_ADDR;
    localparam int ROM_NBIT_DATA = NBIT_PERIOD_DEF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } osc_state_t;

endpackage : synth_pkg
`default_nettype wire

// File: rtl/saw_osc_if.sv
`default_nettype none
// ============================================================================
// Module      : saw_osc_if
// Description : Period/load input and ramp output bundle of the saw oscillator.
// Revision    : 1.0
// ============================================================================
interface saw_osc_if #(
    parameter int NBIT_PERIOD = 16,
    parameter int NBIT_OUT    = 16
);
    logic                   note_on;
    logic                   load;
    logic [NBIT_PERIOD-1:0] period;
    logic [NBIT_OUT-1:0]    sample;
    logic                   step_stb;
    logic                   wrap_stb;
    logic                   active;
    logic [NBIT_PERIOD-1:0] cur;

    modport master (
        output note_on, load, period,
        input  sample, step_stb, wrap_stb, active, cur
    );

    modport slave (
        input  note_on, load, period,
        output sample, step_stb, wrap_stb, active, cur
    );
endinterface : saw_osc_if
`default_nettype wire

// File: rtl/saw_step_timer.sv
`default_nettype none
// ============================================================================
// Module      : saw_step_timer
// Description : Per-step down-counter; reloads from pend and flags boundaries.
// Revision    : 1.0
// ============================================================================
module saw_step_timer #(
    parameter int NBIT_PERIOD = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   run,
    input  wire logic [NBIT_PERIOD-1:0] pend,
    output logic                        tick
);

    localparam logic [NBIT_PERIOD-1:0] C_ONE = NBIT_PERIOD'(1);

    logic [NBIT_PERIOD-1:0] r_cnt;

    // Boundary is combinational so the FSM can act on it in the same cycle
    assign tick = run && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!run || r_cnt == '0) begin
            r_cnt <= pend - C_ONE;
        end else begin
            r_cnt <= r_cnt - C_ONE;
        end
    end

endmodule : saw_step_timer
`default_nettype wire

// File: rtl/saw_osc.sv
`default_nettype none
// ============================================================================
// Module      : saw_osc
// Description : Sawtooth oscillator stepping a phase counter every `period`
//               cycles. Macro SAW_OSC_SIGNED_OUT_EN selects two's-complement
//               output; otherwise the ramp is unsigned.
// Revision    : 1.0
// ============================================================================
module saw_osc
    import synth_pkg::*;
#(
    parameter int NBIT_PERIOD = NBIT_PERIOD_DEF,
    parameter int NBIT_STEP   = NBIT_STEP_DEF,
    parameter int NBIT_OUT    = NBIT_OUT_DEF
) (
    input  wire logic clk,
    input  wire logic rst,
    saw_osc_if.slave  bus
);

    localparam logic [NBIT_STEP-1:0] C_PH_ONE = NBIT_STEP'(1);
    localparam int                   C_SHIFT  = NBIT_OUT - NBIT_STEP;

    osc_state_t             r_state;
    osc_state_t             w_state_nxt;
    logic [NBIT_PERIOD-1:0] r_pend;
    logic [NBIT_PERIOD-1:0] r_cur;
    logic [NBIT_PERIOD-1:0] w_cur_nxt;
    logic [NBIT_STEP-1:0]   r_phase;
    logic [NBIT_STEP-1:0]   w_phase_nxt;
    logic [NBIT_OUT-1:0]    r_sample;
    logic [NBIT_OUT-1:0]    w_sample_nxt;
    logic                   r_step_stb;
    logic                   w_step_nxt;
    logic                   r_wrap_stb;
    logic                   w_wrap_nxt;
    logic                   r_active;
    logic                   w_tick;

    saw_step_timer #(
        .NBIT_PERIOD (NBIT_PERIOD)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .run  (r_state == RUN),
        .pend (r_pend),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pend     <= '0;
            r_cur      <= '0;
            r_phase    <= '0;
            r_sample   <= '0;
            r_step_stb <= 1'b0;
            r_wrap_stb <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            if (bus.load) begin
                r_pend <= bus.period;
            end
            r_cur      <= w_cur_nxt;
            r_phase    <= w_phase_nxt;
            r_sample   <= w_sample_nxt;
            r_step_stb <= w_step_nxt;
            r_wrap_stb <= w_wrap_nxt;
            r_active   <= (w_state_nxt == RUN);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cur_nxt    = r_cur;
        w_phase_nxt  = r_phase;
        w_step_nxt   = 1'b0;
        w_wrap_nxt   = 1'b0;
        w_sample_nxt = '0;

        case (r_state)
            IDLE: begin
                w_cur_nxt   = r_pend;
                w_phase_nxt = '0;
                if (bus.note_on && r_pend != '0) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                // Gate-off outranks a boundary landing in the same cycle
                if (!bus.note_on) begin
                    w_state_nxt = IDLE;
                    w_phase_nxt = '0;
                end else if (w_tick) begin
                    if (r_pend == '0) begin
                        w_state_nxt = IDLE;
                        w_phase_nxt = '0;
                    end else begin
                        w_cur_nxt   = r_pend;
                        w_phase_nxt = r_phase + C_PH_ONE;
                        w_step_nxt  = 1'b1;
                        w_wrap_nxt  = &r_phase;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_phase_nxt = '0;
            end
        endcase

        if (w_state_nxt == RUN) begin
            w_sample_nxt = NBIT_OUT'(w_phase_nxt) << C_SHIFT;
`ifdef SAW_OSC_SIGNED_OUT_EN
            w_sample_nxt[NBIT_OUT-1] = ~w_sample_nxt[NBIT_OUT-1];
`endif
        end
    end

    assign bus.sample   = r_sample;
    assign bus.step_stb = r_step_stb;
    assign bus.wrap_stb = r_wrap_stb;
    assign bus.active   = r_active;
    assign bus.cur      = r_cur;

endmodule : saw_osc
`default_nettype wire

// File: tb/tb_saw_osc.sv
`default_nettype none
// ============================================================================
// Module      : tb_saw_osc
// Description : Directed bench; expected step events are queued and checked
//               by an independent monitor.
// Revision    : 1.0
// ============================================================================
module tb_saw_osc;

    typedef struct {
        int edge_no;
        int ph;
        bit wrap;
    } step_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    step_t sb[$];

    saw_osc_if #(.NBIT_PERIOD(16), .NBIT_OUT(16)) bus ();

    saw_osc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] exp_sample(input int ph);
        logic [5:0]  p;
        logic [15:0] v;
        p = ph[5:0];
        v = {p, 10'b0};
`ifdef SAW_OSC_SIGNED_OUT_EN
        v[15] = ~v[15];
`endif
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_step(input int edge_no, input int k);
        step_t s;
        s.edge_no = edge_no;
        s.ph      = k % 64;
        s.wrap    = (k % 64 == 0);
        sb.push_back(s);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: every strobe must match the head of the expected-step queue
    always @(negedge clk) begin
        step_t e;
        while (sb.size() > 0 && sb[0].edge_no < cyc) begin
            n_checks++;
            n_err++;
            $display("FAIL missing_step: expected step at cycle %0d, still absent at %0d", sb[0].edge_no, cyc);
            void'(sb.pop_front());
        end
        if (bus.step_stb === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_step at cycle %0d: got step_stb 1 expected 0", cyc);
            end else begin
                e = sb.pop_front();
                check("step_cycle", cyc, e.edge_no);
                check("step_sample", {16'b0, bus.sample}, {16'b0, exp_sample(e.ph)});
                check("step_wrap", {31'b0, bus.wrap_stb}, {31'b0, e.wrap});
            end
        end else if (bus.wrap_stb === 1'b1) begin
            n_checks++;
            n_err++;
            $display("FAIL lone_wrap at cycle %0d: got wrap_stb 1 expected 0", cyc);
        end
    end

    initial begin
        int e0, e2, g, c;
        rst         = 1'b1;
        bus.note_on = 1'b0;
        bus.load    = 1'b0;
        bus.period  = '0;
        repeat (3) @(negedge clk);
        check("rst_sample", {16'b0, bus.sample}, 32'h0);
        check("rst_step", {31'b0, bus.step_stb}, 32'h0);
        check("rst_wrap", {31'b0, bus.wrap_stb}, 32'h0);
        check("rst_active", {31'b0, bus.active}, 32'h0);

        // Period 7 run through a wrap, then a mid-step change to period 3
        rst        = 1'b0;
        bus.load   = 1'b1;
        bus.period = 16'd7;
        @(negedge clk);
        bus.load    = 1'b0;
        bus.note_on = 1'b1;
        e0 = cyc + 1;
        for (int k = 1; k <= 70; k++) push_step(e0 + 7 * k, k);
        for (int k = 71; k <= 80; k++) push_step(e0 + 497 + 3 * (k - 71), k);
        @(negedge clk);
        check("entry_active", {31'b0, bus.active}, 32'h1);
        check("entry_sample", {16'b0, bus.sample}, {16'b0, exp_sample(0)});
        wait_until(e0 + 492);
        bus.load   = 1'b1;
        bus.period = 16'd3;
        @(negedge clk);
        bus.load = 1'b0;

        // Period 0 mutes at the next boundary without a strobe
        wait_until(e0 + 524);
        bus.load   = 1'b1;
        bus.period = 16'd0;
        @(negedge clk);
        bus.load = 1'b0;
        wait_until(e0 + 526);
        check("mute_pre_active", {31'b0, bus.active}, 32'h1);
        check("mute_pre_sample", {16'b0, bus.sample}, {16'b0, exp_sample(16)});
        @(negedge clk);
        check("mute_active", {31'b0, bus.active}, 32'h0);
        check("mute_sample", {16'b0, bus.sample}, 32'h0);

        // Reload period 4 with the gate still high: restart from phase 0
        wait_until(e0 + 529);
        bus.load   = 1'b1;
        bus.period = 16'd4;
        @(negedge clk);
        bus.load = 1'b0;
        e2 = cyc + 1;
        for (int k = 1; k <= 5; k++) push_step(e2 + 4 * k, k);
        @(negedge clk);
        check("restart_active", {31'b0, bus.active}, 32'h1);

        // Gate-off on a boundary edge
        wait_until(e2 + 23);
        bus.note_on = 1'b0;
        @(negedge clk);
        check("gateoff_active", {31'b0, bus.active}, 32'h0);
        check("gateoff_sample", {16'b0, bus.sample}, 32'h0);

        // Period 1: a step every cycle, wrap, then reset at phase 37
        bus.load   = 1'b1;
        bus.period = 16'd1;
        @(negedge clk);
        bus.load    = 1'b0;
        bus.note_on = 1'b1;
        g = cyc + 1;
        for (int k = 1; k <= 101; k++) push_step(g + k, k);
        wait_until(g + 101);
        check("pre_rst_sample", {16'b0, bus.sample}, {16'b0, exp_sample(37)});
        rst = 1'b1;
        @(negedge clk);
        check("midrst_sample", {16'b0, bus.sample}, 32'h0);
        check("midrst_step", {31'b0, bus.step_stb}, 32'h0);
        check("midrst_wrap", {31'b0, bus.wrap_stb}, 32'h0);
        check("midrst_active", {31'b0, bus.active}, 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_idle", {31'b0, bus.active}, 32'h0);
        check("post_rst_sample", {16'b0, bus.sample}, 32'h0);

        // Load after reset resumes from the IDLE state
        c = cyc;
        bus.load   = 1'b1;
        bus.period = 16'd2;
        @(negedge clk);
        bus.load = 1'b0;
        for (int k = 1; k <= 3; k++) push_step(c + 2 + 2 * k, k);
        @(negedge clk);
        check("reload_active", {31'b0, bus.active}, 32'h1);
        wait_until(c + 8);
        bus.note_on = 1'b0;
        repeat (4) @(negedge clk);
        check("final_active", {31'b0, bus.active}, 32'h0);
        check("queue_empty", sb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_saw_osc
`default_nettype wire
